// File: rtl/buzzer_event_monitor_if.sv
// Event stream from the buzzer monitor's FIFO head to a host or logger.
// Valid/ready handshake: the head is consumed when evt_valid & evt_ready.
interface buzzer_event_monitor_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_chan;
  logic       evt_start;

  modport master (output evt_valid, evt_chan, evt_start, input evt_ready);
  modport slave  (input evt_valid, evt_chan, evt_start, output evt_ready);
endinterface

// File: rtl/buzzer_event_monitor.sv
// Watches the buzzer lines, decides per-channel activity once per window, and queues
// start/stop events for channels whose activity changed, scanned in ascending order.
module buzzer_event_monitor #(
  parameter int NCH       = 8,
  parameter int WIN       = 16,
  parameter int MIN_EDGES = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         buzz_in,
  buzzer_event_monitor_if.master evt,
  output logic [NCH-1:0]         active_mask,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(MIN_EDGES + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  logic [NCH-1:0] sync1_q, sync_q, sync_prev_q, rise, new_mask;
  logic [NCH-1:0] active_mask_q, diff_q;
  logic [WW-1:0]  win_cnt_q;
  logic           win_start, win_end;

  assign rise      = sync_q & ~sync_prev_q;
  assign win_start = (win_cnt_q == '0);
  assign win_end   = (win_cnt_q == WW'(WIN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      sync1_q     <= buzz_in;
      sync_q      <= sync1_q;
      sync_prev_q <= sync_q;
      win_cnt_q   <= win_end ? '0 : win_cnt_q + 1'b1;
    end
  end

  // The current cycle's sample is folded in before judging, so the verdict at
  // window end covers all WIN samples of the window.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [EW-1:0] edges_q, edges_d, base_edges;
    logic          saw_low_q, saw_low_d, base_low;

    always_comb begin
      base_edges = win_start ? '0 : edges_q;
      base_low   = win_start ? 1'b0 : saw_low_q;
      edges_d    = base_edges;
      if (rise[gi] && (base_edges < EW'(MIN_EDGES))) begin
        edges_d = base_edges + 1'b1;
      end
      saw_low_d  = base_low | ~sync_q[gi];
    end

    assign new_mask[gi] = (edges_d >= EW'(MIN_EDGES)) || !saw_low_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        edges_q   <= '0;
        saw_low_q <= 1'b0;
      end else begin
        edges_q   <= edges_d;
        saw_low_q <= saw_low_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_mask_q <= '0;
      diff_q        <= '0;
    end else if (win_end) begin
      active_mask_q <= new_mask;
      diff_q        <= active_mask_q ^ new_mask;
    end
  end

  assign active_mask = active_mask_q;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       push;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_end && ((active_mask_q ^ new_mask) != '0)) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        push  = diff_q[idx_q];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(NCH - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  logic [2:0]    chan_mem_q  [DEPTH];
  logic          start_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop, push_ok, drop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop     = (count_q != '0) && evt.evt_ready;
  assign push_ok = push && ((count_q < (AW+1)'(DEPTH)) || pop);
  assign drop    = push && !push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        chan_mem_q[i]  <= '0;
        start_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        chan_mem_q[wr_ptr_q]  <= idx_q;
        start_mem_q[wr_ptr_q] <= active_mask_q[idx_q];
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (count_q != '0);
  assign evt.evt_chan  = chan_mem_q[rd_ptr_q];
  assign evt.evt_start = start_mem_q[rd_ptr_q];
endmodule
